// File: rtl/dlfloat16_pkg.sv
// Shared DLFloat16 format constants and the converter FSM state encoding.
package dlfloat16_pkg;

  localparam int          EXP_W       = 6;
  localparam int          FRAC_W      = 9;
  localparam int          BIAS        = 31;
  localparam logic [5:0]  EXP_INF     = 6'h3F;
  localparam logic [5:0]  EXP_MAX_FIN = 6'h3E;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dlf16_round_rne.sv
// Round-to-nearest-even packer: takes a magnitude normalised so that bit 31
// is the hidden one, plus its biased exponent and sign, and produces the
// DLFloat16 word and an inexact flag. Purely combinational so other narrowing
// paths can reuse it. A clear bit 31 means the caller has no leading one
// (zero magnitude) and yields a signed zero.
module dlf16_round_rne
  import dlfloat16_pkg::*;
(
  input  logic [31:0] mag_i,
  input  logic [5:0]  exp_i,
  input  logic        sign_i,
  output logic [15:0] res_o,
  output logic        inexact_o
);

  logic [FRAC_W-1:0] frac;
  logic [FRAC_W-1:0] frac_r;
  logic [EXP_W-1:0]  exp_r;
  logic              lsb;
  logic              guard;
  logic              sticky;
  logic              inc;

  // Extract fraction/guard/sticky and apply the half-to-even increment.
  always_comb begin
    frac   = mag_i[30:22];
    lsb    = mag_i[22];
    guard  = mag_i[21];
    sticky = |mag_i[20:0];
    inc    = guard & (sticky | lsb);
    exp_r  = exp_i;
    frac_r = frac;
    if (inc) begin
      if (frac == {FRAC_W{1'b1}}) begin
        // Fraction overflow carries into the exponent; the exponent range
        // of the callers never reaches EXP_INF, so no saturation is needed.
        frac_r = '0;
        exp_r  = exp_i + 6'd1;
      end else begin
        frac_r = frac + {{(FRAC_W-1){1'b0}}, 1'b1};
      end
    end
    if (!mag_i[31]) begin
      res_o     = {sign_i, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
      inexact_o = 1'b0;
    end else begin
      res_o     = {sign_i, exp_r, frac_r};
      inexact_o = guard | sticky;
    end
  end

endmodule

// File: rtl/int32_to_float16.sv
// Iterative signed-integer to DLFloat16 converter with valid/ready on both
// sides and one conversion in flight.
// Optional build macro FAST_NORM_EN: normalisation skips 8 leading zeros per
// cycle when possible; results are identical, only latency shrinks.
module int32_to_float16
  import dlfloat16_pkg::*;
#(
  parameter int INT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_inexact
);

  // Exponent of a value whose leading one sits at bit 31 after left-aligning
  // an INT_W-bit magnitude: bit (INT_W-1) of the integer has weight
  // 2^(INT_W-1), biased by 31. Equals 62 for the 32-bit case.
  localparam logic [5:0] EXP_ALIGN = 6'(BIAS + INT_W - 1);

  state_t      state_q;
  logic [31:0] mag_q;
  logic [5:0]  exp_q;
  logic        sign_q;
  logic [15:0] out_data_q;
  logic        out_inexact_q;
  logic        out_valid_q;

  logic [INT_W-1:0] abs_d;
  logic [31:0]      mag_align_d;
  logic [15:0]      round_res;
  logic             round_inexact;

  // Magnitude is taken as unsigned INT_W bits so the most negative value is exact.
  assign abs_d       = in_data[INT_W-1] ? (~in_data + {{(INT_W-1){1'b0}}, 1'b1}) : in_data;
  assign mag_align_d = 32'(abs_d) << (32 - INT_W);

  dlf16_round_rne u_round (
    .mag_i     (mag_q),
    .exp_i     (exp_q),
    .sign_i    (sign_q),
    .res_o     (round_res),
    .inexact_o (round_inexact)
  );

  // Control FSM with its datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mag_q         <= '0;
      exp_q         <= '0;
      sign_q        <= 1'b0;
      out_data_q    <= 16'h0000;
      out_inexact_q <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q <= in_data[INT_W-1];
            mag_q  <= mag_align_d;
            exp_q  <= EXP_ALIGN;
            if (mag_align_d == 32'd0) begin
              out_data_q    <= 16'h0000;
              out_inexact_q <= 1'b0;
              out_valid_q   <= 1'b1;
              state_q       <= DONE;
            end else begin
              state_q <= NORM;
            end
          end
        end
        NORM: begin
          if (mag_q[31]) begin
            state_q <= ROUND;
`ifdef FAST_NORM_EN
          end else if (mag_q[31:24] == 8'd0) begin
            mag_q <= mag_q << 8;
            exp_q <= exp_q - 6'd8;
`endif
          end else begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 6'd1;
          end
        end
        ROUND: begin
          out_data_q    <= round_res;
          out_inexact_q <= round_inexact;
          out_valid_q   <= 1'b1;
          state_q       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_inexact = out_inexact_q;

endmodule
